// File: rtl/ir_receiver_sm.sv
// ir_receiver_sm: decodes the car-control IR packet into a 4-bit direction command.
// Optional build macro IR_RX_ENVELOPE_EN: derive the envelope from a raw carrier-modulated input.
`default_nettype none

module ir_receiver_sm #(
  parameter int CLKS_PER_PULSE = 2778,
  parameter int ENV_HOLD_CLKS  = 5556,
  parameter int START_MIN      = 160,
  parameter int START_MAX      = 220,
  parameter int CARSEL_MIN     = 35,
  parameter int CARSEL_MAX     = 60,
  parameter int DEASSERT_MIN   = 12,
  parameter int ASSERT_MIN     = 35,
  parameter int ASSERT_MAX     = 60,
  parameter int GAP_MIN        = 15,
  parameter int GAP_MAX        = 40
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       IR_IN,
  output logic [3:0] COMMAND,
  output logic       PACKET_VALID,
  output logic       PACKET_ERROR
);

  // One counter width serves both the carrier prescaler and the envelope hold counter.
  localparam int CNT_MAX = (CLKS_PER_PULSE > ENV_HOLD_CLKS) ? CLKS_PER_PULSE : ENV_HOLD_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CLKS_PER_PULSE - 1);
  localparam logic [7:0]       START_LO  = 8'(START_MIN);
  localparam logic [7:0]       START_HI  = 8'(START_MAX);
  localparam logic [7:0]       CARSEL_LO = 8'(CARSEL_MIN);
  localparam logic [7:0]       CARSEL_HI = 8'(CARSEL_MAX);
  localparam logic [7:0]       ZERO_LO   = 8'(DEASSERT_MIN);
  localparam logic [7:0]       ZERO_HI   = 8'(ASSERT_MIN - 1);
  localparam logic [7:0]       ONE_LO    = 8'(ASSERT_MIN);
  localparam logic [7:0]       ONE_HI    = 8'(ASSERT_MAX);
  localparam logic [7:0]       GAP_LO    = 8'(GAP_MIN);
  localparam logic [7:0]       GAP_HI    = 8'(GAP_MAX);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_CARSEL = 2'd1,
    S_WAIT_DIR    = 2'd2,
    S_DONE        = 2'd3
  } state_t;

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic             sync1, sync2;
  logic             env, env_d;
  logic             env_rise, env_fall;
  logic [CNT_W-1:0] pre_cnt;
  logic [7:0]       len_cnt;
  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [3:0]       shadow, shadow_n;
  logic             err;
  logic             is_start, is_carsel, is_zero, is_one;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= IR_IN;
      sync2 <= sync1;
    end
  end

`ifdef IR_RX_ENVELOPE_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ENV_HOLD_CLKS - 1);

  logic             sync_d;
  logic             env_r;
  logic [CNT_W-1:0] hold_cnt;

  // Each carrier rising edge restarts the hold window; silence for the full window ends the burst.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_d   <= 1'b0;
      env_r    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      sync_d <= sync2;
      if (sync2 && !sync_d) begin
        env_r    <= 1'b1;
        hold_cnt <= '0;
      end else if (env_r) begin
        if (hold_cnt == HOLD_LAST) begin
          env_r <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

  assign env = env_r;
`else
  assign env = sync2;
`endif

  assign env_rise = env && !env_d;
  assign env_fall = !env && env_d;

  // An edge clears the measurement; a tick landing on the same clock is dropped.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      env_d   <= 1'b0;
      pre_cnt <= '0;
      len_cnt <= '0;
    end else begin
      env_d <= env;
      if (env_rise || env_fall) begin
        pre_cnt <= '0;
        len_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        if (len_cnt != 8'hFF) begin
          len_cnt <= len_cnt + 8'd1;
        end
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  assign is_start  = in_range(len_cnt, START_LO, START_HI);
  assign is_carsel = in_range(len_cnt, CARSEL_LO, CARSEL_HI);
  assign is_zero   = in_range(len_cnt, ZERO_LO, ZERO_HI);
  assign is_one    = in_range(len_cnt, ONE_LO, ONE_HI);

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    shadow_n = shadow;
    err      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (env_fall && is_start) begin
          state_n = S_WAIT_CARSEL;
        end
      end
      S_WAIT_CARSEL: begin
        if (env_fall) begin
          if (is_carsel) begin
            state_n  = S_WAIT_DIR;
            idx_n    = 2'd0;
            shadow_n = 4'd0;
          end else begin
            err = 1'b1;
          end
        end else if (env_rise) begin
          err = (len_cnt < GAP_LO);
        end else if (!env && (len_cnt > GAP_HI)) begin
          err = 1'b1;
        end
      end
      S_WAIT_DIR: begin
        if (env_fall) begin
          if (is_zero || is_one) begin
            shadow_n[2'd3 - idx] = is_one;
            idx_n                = idx + 2'd1;
            if (idx == 2'd3) begin
              state_n = S_DONE;
            end
          end else begin
            err = 1'b1;
          end
        end else if (env_rise) begin
          err = (len_cnt < GAP_LO);
        end else if (!env && (len_cnt > GAP_HI)) begin
          err = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // A Start-length burst that breaks a packet is treated as the start of the next one.
    if (err) begin
      state_n  = (env_fall && is_start) ? S_WAIT_CARSEL : S_IDLE;
      shadow_n = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state        <= S_IDLE;
      idx          <= 2'd0;
      shadow       <= 4'd0;
      COMMAND      <= 4'd0;
      PACKET_VALID <= 1'b0;
      PACKET_ERROR <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      shadow       <= shadow_n;
      PACKET_ERROR <= err;
      PACKET_VALID <= (state == S_DONE);
      if (state == S_DONE) begin
        COMMAND <= shadow;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ir_receiver_sm.sv
// tb_ir_receiver_sm: table-driven packet vectors with a command scoreboard, plus reset and noise sequences.
`default_nettype none

module tb_ir_receiver_sm;

  localparam int CPP    = 10;
  localparam int HOLD   = 20;
  localparam int IDLE_P = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir_in = 1'b0;
  logic [3:0] command;
  logic       packet_valid;
  logic       packet_error;

  always #5 clk = ~clk;

  ir_receiver_sm #(
    .CLKS_PER_PULSE(CPP),
    .ENV_HOLD_CLKS (HOLD)
  ) dut (
    .CLK         (clk),
    .RESETN      (rst_n),
    .IR_IN       (ir_in),
    .COMMAND     (command),
    .PACKET_VALID(packet_valid),
    .PACKET_ERROR(packet_error)
  );

  typedef struct {
    logic [3:0] cmd;
    int         over_idx;
    int         over_len;
    int         carsel_gap;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  int         n_vec = 0;
  int         n_fail = 0;
  int         n_valid = 0;
  int         n_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_cmd = 4'd0;
  vec_t       vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock, sampling DUT outputs on the falling edge.
  task automatic step();
    @(negedge clk);
    if (packet_valid && packet_error) check("valid_and_error_together", 1, 0);
    if (packet_valid && prev_valid) check("valid_pulse_width", 2, 1);
    if (packet_error && prev_err) check("error_pulse_width", 2, 1);
    if (packet_valid) begin
      n_valid++;
      if (sb_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("command", int'(command), int'(sb_q.pop_front()));
    end
    if (packet_error) n_err++;
    prev_valid = packet_valid;
    prev_err   = packet_error;
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n);
`ifdef IR_RX_ENVELOPE_EN
    repeat (n) begin
      ir_in = 1'b1;
      repeat (CPP / 2) step();
      ir_in = 1'b0;
      repeat (CPP - CPP / 2) step();
    end
`else
    ir_in = 1'b1;
    repeat (n * CPP) step();
    ir_in = 1'b0;
`endif
  endtask

  task automatic gap(input int n);
    ir_in = 1'b0;
    repeat (n * CPP) step();
  endtask

  task automatic send(input logic [3:0] cmd, input int over_idx, input int over_len, input int carsel_gap);
    burst(191);
    gap(25);
    burst(47);
    gap(carsel_gap);
    for (int i = 0; i < 4; i++) begin
      if (i == over_idx) burst(over_len);
      else burst(cmd[3-i] ? 47 : 22);
      gap(25);
    end
    gap(IDLE_P);
  endtask

  initial begin
    int v0, e0;

    vecs[0] = '{4'b1010, -1, 0, 25, 1'b1, 1'b0};
    vecs[1] = '{4'b0000, -1, 0, 25, 1'b1, 1'b0};
    vecs[2] = '{4'b1111, -1, 0, 25, 1'b1, 1'b0};
    vecs[3] = '{4'b0110,  1, 80, 25, 1'b0, 1'b1};
    vecs[4] = '{4'b0001, -1, 0, 60, 1'b0, 1'b1};
    vecs[5] = '{4'b0101, -1, 0, 25, 1'b1, 1'b0};

    rst_n = 1'b0;
    repeat (3) step();
    check("reset_command", int'(command), 0);
    check("reset_valid", int'(packet_valid), 0);
    check("reset_error", int'(packet_error), 0);
    rst_n = 1'b1;
    gap(5);

    for (int k = 0; k < 6; k++) begin
      v0 = n_valid;
      e0 = n_err;
      if (vecs[k].exp_valid) begin
        sb_q.push_back(vecs[k].cmd);
        exp_cmd = vecs[k].cmd;
      end
      send(vecs[k].cmd, vecs[k].over_idx, vecs[k].over_len, vecs[k].carsel_gap);
      check($sformatf("vec%0d_valid_count", k), n_valid - v0, int'(vecs[k].exp_valid));
      check($sformatf("vec%0d_error_count", k), n_err - e0, int'(vecs[k].exp_err));
      check($sformatf("vec%0d_command", k), int'(command), int'(exp_cmd));
      check($sformatf("vec%0d_scoreboard_empty", k), sb_q.size(), 0);
    end

    // Reset during the Backward burst of 4'b0011.
    v0 = n_valid;
    e0 = n_err;
    burst(191);
    gap(25);
    burst(47);
    gap(25);
    burst(22);
    gap(25);
    burst(22);
    gap(25);
    burst(20);
    rst_n = 1'b0;
    ir_in = 1'b0;
    repeat (3) step();
    check("midreset_command", int'(command), 0);
    check("midreset_valid", int'(packet_valid), 0);
    check("midreset_error", int'(packet_error), 0);
    rst_n = 1'b1;
    gap(IDLE_P);
    check("midreset_no_strobes", (n_valid - v0) + (n_err - e0), 0);
    sb_q.push_back(4'b0011);
    send(4'b0011, -1, 0, 25);
    check("after_reset_valid_count", n_valid - v0, 1);
    check("after_reset_command", int'(command), 3);
    check("after_reset_error_count", n_err - e0, 0);

    // Short noise bursts in IDLE are ignored.
    v0 = n_valid;
    e0 = n_err;
    repeat (5) begin
      burst(5);
      gap(25);
    end
    gap(IDLE_P);
    check("noise_valid_count", n_valid - v0, 0);
    check("noise_error_count", n_err - e0, 0);
    check("noise_command_hold", int'(command), 3);
    check("final_scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
